plca_ctrl_sync: RTL and testbench

//  Clocked, parametrised PLCA control state machine (Clause 148.4.4 behaviour) with its timers built in.

---
 rtl/plca_ctrl_sync.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_plca_ctrl_sync.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plca_ctrl_sync.sv
// plca_ctrl_sync: clocked PLCA control state machine with built-in cycle-count timers.
// Sits between the RS/PCS status inputs and the PLCA data path outputs.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   plca_en               PLCA enable
//   local_node_id         this node's ID (0 = coordinator, all-ones = unassigned)
//   node_count            TOs per cycle (coordinator only)
//   max_bc                maximum burst count
//   pmcd, crs, tx_en, col, receiving, packet_pending   PHY/MAC status
//   rx_cmd / tx_cmd       00 BEACON, 01 COMMIT, 10 NONE
//   committed             node owns the current TO
//   plca_active           PLCA cycle synchronised
//   cur_id, bc            current TO owner, burst count
//   txop_end              one-cycle pulse on each NEXT_TXOP entry
//   state                 observable FSM state
module plca_ctrl_sync #(
  parameter int unsigned ID_W           = 8,
  parameter int unsigned BC_W           = 8,
  parameter int unsigned TO_CYC         = 32,
  parameter int unsigned BEACON_CYC     = 20,
  parameter int unsigned BEACON_DET_CYC = 22,
  parameter int unsigned BURST_CYC      = 128,
  parameter int unsigned INV_BEACON_CYC = 4000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            plca_en,
  input  logic [ID_W-1:0] local_node_id,
  input  logic [ID_W-1:0] node_count,
  input  logic [BC_W-1:0] max_bc,
  input  logic            pmcd,
  input  logic            crs,
  input  logic            tx_en,
  input  logic            col,
  input  logic            receiving,
  input  logic            packet_pending,
  input  logic [1:0]      rx_cmd,
  output logic [1:0]      tx_cmd,
  output logic            committed,
  output logic            plca_active,
  output logic [ID_W-1:0] cur_id,
  output logic [BC_W-1:0] bc,
  output logic            txop_end,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    StDisable    = 4'h0, StResync  = 4'h1, StRecover  = 4'h2, StSendBeacon = 4'h3,
    StSyncing    = 4'h4, StWaitTo  = 4'h5, StEarlyRx  = 4'h6, StCommit     = 4'h7,
    StYield      = 4'h8, StReceive = 4'h9, StTransmit = 4'hA, StBurst      = 4'hB,
    StNextTxop   = 4'hC, StAbort   = 4'hD
  } state_e;

  localparam logic [1:0] CmdBeacon = 2'b00;
  localparam logic [1:0] CmdCommit = 2'b01;
  localparam logic [1:0] CmdNone   = 2'b10;

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Timer bank: index constants and shared counter width.
  localparam int NT      = 5;
  localparam int TTo     = 0;
  localparam int TBeacon = 1;
  localparam int TDet    = 2;
  localparam int TBurst  = 3;
  localparam int TInv    = 4;
  localparam int unsigned TMax = max2(max2(max2(TO_CYC, BEACON_CYC), max2(BEACON_DET_CYC,
                                      BURST_CYC)), INV_BEACON_CYC);
  localparam int unsigned TW = $clog2(TMax + 1);
  // Loaded with LEN-1 so that a start decided in cycle N shows expiry in cycle N+LEN.
  localparam logic [NT-1:0][TW-1:0] TLoad = {TW'(INV_BEACON_CYC - 1), TW'(BURST_CYC - 1),
                                             TW'(BEACON_DET_CYC - 1), TW'(BEACON_CYC - 1),
                                             TW'(TO_CYC - 1)};

  state_e            state_q, state_d;
  logic [1:0]        tx_cmd_q, tx_cmd_d;
  logic              committed_q, committed_d;
  logic              plca_active_q, plca_active_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              txop_end_q, txop_end_d;

  logic [NT-1:0]         t_run_q, t_run_d, t_start, t_stop, t_exp;
  logic [NT-1:0][TW-1:0] t_cnt_q, t_cnt_d;
  logic                  to_running, det_running;

  logic id_zero, id_ones, id_match, is_beacon, inv_fire;
  logic unused_col;

  assign unused_col = col;
  assign id_zero    = (local_node_id == '0);
  assign id_ones    = (local_node_id == '1);
  assign id_match   = (cur_id_q == local_node_id);
  assign is_beacon  = (rx_cmd == CmdBeacon);

  // Expired is a held level: counter at zero while still armed.
  always_comb begin
    for (int i = 0; i < NT; i++) begin
      t_exp[i] = t_run_q[i] && (t_cnt_q[i] == '0);
    end
    to_running  = t_run_q[TTo] && (t_cnt_q[TTo] != '0);
    det_running = t_run_q[TDet] && (t_cnt_q[TDet] != '0);
  end

  // Next-state selection.
  always_comb begin
    state_d  = state_q;
    inv_fire = 1'b0;
    if (!plca_en || id_ones) begin
      state_d = StDisable;
    end else if (t_exp[TInv]) begin
      state_d  = StResync;
      inv_fire = 1'b1;
    end else begin
      unique case (state_q)
        StDisable:    state_d = id_zero ? StRecover : StResync;
        StResync: begin
          if (id_zero && pmcd && !crs && !tx_en) state_d = StSendBeacon;
          else if (!id_zero && crs)              state_d = StEarlyRx;
        end
        StRecover:    state_d = StWaitTo;
        StSendBeacon: if (t_exp[TBeacon]) state_d = StSyncing;
        StSyncing:    if (!crs) state_d = StWaitTo;
        StWaitTo: begin
          if (crs)                                       state_d = StEarlyRx;
          else if (id_match && packet_pending && plca_active_q) state_d = StCommit;
          else if (id_match)                             state_d = StYield;
          else if (t_exp[TTo])                           state_d = StNextTxop;
        end
        StEarlyRx: begin
          if (receiving && crs) state_d = StReceive;
          else if (!id_zero && !receiving && (is_beacon || (!crs && det_running)))
            state_d = StSyncing;
          else if (id_zero && !crs)                    state_d = StRecover;
          else if (!id_zero && !crs && t_exp[TDet])    state_d = StResync;
        end
        StCommit: begin
          if (tx_en)                state_d = StTransmit;
          else if (!packet_pending) state_d = StAbort;
        end
        StYield: begin
          if (crs && to_running) state_d = StEarlyRx;
          else if (t_exp[TTo])   state_d = StNextTxop;
        end
        StReceive:    if (!crs) state_d = StNextTxop;
        StTransmit: begin
          if (!tx_en && (bc_q < max_bc)) state_d = StBurst;
          else if (!tx_en && !crs)       state_d = StNextTxop;
        end
        StBurst: begin
          if (tx_en)                state_d = StTransmit;
          else if (t_exp[TBurst])   state_d = StAbort;
        end
        StNextTxop: begin
          if ((id_zero && (cur_id_q >= node_count)) || (cur_id_q == '1)) state_d = StResync;
          else                                                           state_d = StWaitTo;
        end
        StAbort:      if (!crs) state_d = StNextTxop;
        default:      state_d = StDisable;
      endcase
    end
  end

  // Entry actions and timer commands, applied on the edge that enters the state.
  always_comb begin
    tx_cmd_d      = tx_cmd_q;
    committed_d   = committed_q;
    plca_active_d = plca_active_q;
    cur_id_d      = cur_id_q;
    bc_d          = bc_q;
    txop_end_d    = 1'b0;
    t_start       = '0;
    t_stop        = '0;

    // Followers keep pushing the invalid-beacon deadline out while syncing on non-beacons.
    if (state_q == StSyncing && !id_zero && !is_beacon) t_start[TInv] = 1'b1;

    if (state_d != state_q) begin
      case (state_d)
        StDisable: begin
          tx_cmd_d      = CmdNone;
          committed_d   = 1'b0;
          plca_active_d = 1'b0;
          cur_id_d      = '0;
          bc_d          = '0;
          t_start       = '0;
          t_stop        = '1;
        end
        StResync, StRecover: plca_active_d = 1'b0;
        StSendBeacon: begin
          tx_cmd_d         = CmdBeacon;
          plca_active_d    = 1'b1;
          t_start[TBeacon] = 1'b1;
        end
        StSyncing: begin
          cur_id_d      = '0;
          tx_cmd_d      = CmdNone;
          plca_active_d = 1'b1;
        end
        StWaitTo:  t_start[TTo] = 1'b1;
        StEarlyRx: begin
          t_stop[TTo]   = 1'b1;
          t_start[TDet] = 1'b1;
        end
        StCommit: begin
          tx_cmd_d    = CmdCommit;
          committed_d = 1'b1;
          bc_d        = '0;
          t_stop[TTo] = 1'b1;
        end
        StTransmit: begin
          tx_cmd_d = CmdNone;
          if (bc_q >= max_bc) committed_d = 1'b0;
        end
        StBurst: begin
          bc_d            = (bc_q == '1) ? bc_q : bc_q + BC_W'(1);
          tx_cmd_d        = CmdCommit;
          t_start[TBurst] = 1'b1;
        end
        StNextTxop: begin
          cur_id_d    = cur_id_q + ID_W'(1);
          committed_d = 1'b0;
          txop_end_d  = 1'b1;
        end
        StAbort: begin
          tx_cmd_d    = CmdNone;
          committed_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Disarm on expiry so the held level does not keep forcing RESYNC.
    if (inv_fire) begin
      t_start[TInv] = 1'b0;
      t_stop[TInv]  = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NT; i++) begin
      t_run_d[i] = t_run_q[i];
      t_cnt_d[i] = t_cnt_q[i];
      if (t_start[i]) begin
        t_run_d[i] = 1'b1;
        t_cnt_d[i] = TLoad[i];
      end else if (t_stop[i]) begin
        t_run_d[i] = 1'b0;
      end else if (t_run_q[i] && (t_cnt_q[i] != '0)) begin
        t_cnt_d[i] = t_cnt_q[i] - TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StDisable;
      tx_cmd_q      <= CmdNone;
      committed_q   <= 1'b0;
      plca_active_q <= 1'b0;
      cur_id_q      <= '0;
      bc_q          <= '0;
      txop_end_q    <= 1'b0;
      t_run_q       <= '0;
      t_cnt_q       <= '0;
    end else begin
      state_q       <= state_d;
      tx_cmd_q      <= tx_cmd_d;
      committed_q   <= committed_d;
      plca_active_q <= plca_active_d;
      cur_id_q      <= cur_id_d;
      bc_q          <= bc_d;
      txop_end_q    <= txop_end_d;
      t_run_q       <= t_run_d;
      t_cnt_q       <= t_cnt_d;
    end
  end

  assign tx_cmd      = tx_cmd_q;
  assign committed   = committed_q;
  assign plca_active = plca_active_q;
  assign cur_id      = cur_id_q;
  assign bc          = bc_q;
  assign txop_end    = txop_end_q;
  assign state       = state_q;

endmodule

// File: tb/tb_plca_ctrl_sync.sv
// tb_plca_ctrl_sync: self-checking bench for plca_ctrl_sync with default parameters.
module tb_plca_ctrl_sync;

  localparam int unsigned TO_CYC         = 32;
  localparam int unsigned BEACON_CYC     = 20;
  localparam int unsigned BURST_CYC      = 128;
  localparam int unsigned INV_BEACON_CYC = 4000;

  localparam logic [1:0] BCN = 2'b00;
  localparam logic [1:0] COM = 2'b01;
  localparam logic [1:0] NON = 2'b10;

  localparam logic [3:0] SDis = 4'h0, SRes = 4'h1, SRec = 4'h2, SSnd = 4'h3, SSyn = 4'h4;
  localparam logic [3:0] SWait = 4'h5, SEarly = 4'h6, SCom = 4'h7, SYld = 4'h8;
  localparam logic [3:0] STx = 4'hA, SBur = 4'hB, SNxt = 4'hC, SAbt = 4'hD;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [1:0] tx;
    logic       com;
    logic       act;
    logic [7:0] cur;
    logic [7:0] bc;
    logic       txop;
  } exp_t;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] id;
    logic       crs;
    logic [1:0] rx;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, plca_en, pmcd, crs, tx_en, col, receiving, packet_pending;
  logic [7:0] local_node_id, node_count, max_bc;
  logic [1:0] rx_cmd, tx_cmd;
  logic       committed, plca_active, txop_end;
  logic [7:0] cur_id, bc;
  logic [3:0] state;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  vec_t vecs[13];

  plca_ctrl_sync #(
    .ID_W(8), .BC_W(8), .TO_CYC(TO_CYC), .BEACON_CYC(BEACON_CYC), .BEACON_DET_CYC(22),
    .BURST_CYC(BURST_CYC), .INV_BEACON_CYC(INV_BEACON_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .plca_en(plca_en), .local_node_id(local_node_id),
    .node_count(node_count), .max_bc(max_bc), .pmcd(pmcd), .crs(crs), .tx_en(tx_en),
    .col(col), .receiving(receiving), .packet_pending(packet_pending), .rx_cmd(rx_cmd),
    .tx_cmd(tx_cmd), .committed(committed), .plca_active(plca_active), .cur_id(cur_id),
    .bc(bc), .txop_end(txop_end), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(string n, logic [3:0] st, logic [1:0] tx, logic com, logic act,
                              logic [7:0] cur, logic [7:0] b, logic txop);
    exp_t e;
    e.name = n; e.st = st; e.tx = tx; e.com = com; e.act = act; e.cur = cur; e.bc = b;
    e.txop = txop;
    return e;
  endfunction

  function automatic vec_t mkv(logic r, logic en, logic [7:0] id, logic c, logic [1:0] rx,
                               exp_t e);
    vec_t v;
    v.rst_n = r; v.en = en; v.id = id; v.crs = c; v.rx = rx; v.e = e;
    return v;
  endfunction

  task automatic cmp(input string nm, input string f, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, want %0h", nm, f, a, e);
    end
  endtask

  task automatic check_out(input exp_t e);
    cmp(e.name, "state", 32'(state), 32'(e.st));
    cmp(e.name, "tx_cmd", 32'(tx_cmd), 32'(e.tx));
    cmp(e.name, "committed", 32'(committed), 32'(e.com));
    cmp(e.name, "plca_active", 32'(plca_active), 32'(e.act));
    cmp(e.name, "cur_id", 32'(cur_id), 32'(e.cur));
    cmp(e.name, "bc", 32'(bc), 32'(e.bc));
    cmp(e.name, "txop_end", 32'(txop_end), 32'(e.txop));
  endtask

  // Expectation is queued with the stimulus, then popped once the DUT has responded.
  task automatic step(input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_out(got);
  endtask

  task automatic wait_txop(input string nm, input int exp_n, input int exp_cur);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!txop_end && n < 2000);
    cmp(nm, "edges", 32'(n), 32'(exp_n));
    cmp(nm, "cur_id", 32'(cur_id), 32'(exp_cur));
  endtask

  task automatic sync_follower(input logic [7:0] id);
    plca_en = 1'b0;
    step(mk("sf_dis", SDis, NON, 0, 0, 0, 0, 0));
    plca_en = 1'b1; local_node_id = id;
    step(mk("sf_resync", SRes, NON, 0, 0, 0, 0, 0));
    crs = 1'b1;
    step(mk("sf_early", SEarly, NON, 0, 0, 0, 0, 0));
    rx_cmd = BCN;
    step(mk("sf_sync", SSyn, NON, 0, 1, 0, 0, 0));
    rx_cmd = NON; crs = 1'b0;
    step(mk("sf_wait", SWait, NON, 0, 1, 0, 0, 0));
  endtask

  task automatic sync_to_commit1();
    sync_follower(8'd1);
    wait_txop("sc_txop1", TO_CYC, 1);
    packet_pending = 1'b1;
    step(mk("sc_wait", SWait, NON, 0, 1, 1, 0, 0));
    step(mk("sc_commit", SCom, COM, 1, 1, 1, 0, 0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; plca_en = 1'b1; local_node_id = 8'd0; node_count = 8'd4; max_bc = 8'd0;
    pmcd = 1'b1; crs = 1'b0; tx_en = 1'b0; col = 1'b0; receiving = 1'b0;
    packet_pending = 1'b0; rx_cmd = NON;

    vecs[0]  = mkv(0, 1, 8'd0, 0, NON, mk("rst0", SDis, NON, 0, 0, 0, 0, 0));
    vecs[1]  = mkv(0, 1, 8'd0, 0, NON, mk("rst1", SDis, NON, 0, 0, 0, 0, 0));
    vecs[2]  = mkv(1, 1, 8'd0, 0, NON, mk("recover", SRec, NON, 0, 0, 0, 0, 0));
    vecs[3]  = mkv(1, 1, 8'd0, 0, NON, mk("wait_to", SWait, NON, 0, 0, 0, 0, 0));
    vecs[4]  = mkv(1, 1, 8'd0, 0, NON, mk("yield", SYld, NON, 0, 0, 0, 0, 0));
    vecs[5]  = mkv(1, 0, 8'd0, 0, NON, mk("en_off", SDis, NON, 0, 0, 0, 0, 0));
    vecs[6]  = mkv(1, 1, 8'hFF, 0, NON, mk("id_ff", SDis, NON, 0, 0, 0, 0, 0));
    vecs[7]  = mkv(1, 1, 8'd2, 0, NON, mk("resync", SRes, NON, 0, 0, 0, 0, 0));
    vecs[8]  = mkv(1, 1, 8'd2, 0, NON, mk("resync_hold", SRes, NON, 0, 0, 0, 0, 0));
    vecs[9]  = mkv(1, 1, 8'd2, 1, NON, mk("early_rx", SEarly, NON, 0, 0, 0, 0, 0));
    vecs[10] = mkv(1, 1, 8'd2, 1, BCN, mk("syncing", SSyn, NON, 0, 1, 0, 0, 0));
    vecs[11] = mkv(1, 1, 8'd2, 1, NON, mk("sync_hold", SSyn, NON, 0, 1, 0, 0, 0));
    vecs[12] = mkv(1, 1, 8'd2, 0, NON, mk("wait_f", SWait, NON, 0, 1, 0, 0, 0));

    #1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; plca_en = vecs[i].en; local_node_id = vecs[i].id;
      crs = vecs[i].crs; rx_cmd = vecs[i].rx;
      step(vecs[i].e);
    end

    // Follower id=2 commit and single transmit.
    wait_txop("t3_txop1", TO_CYC, 1);
    wait_txop("t3_txop2", TO_CYC + 1, 2);
    packet_pending = 1'b1;
    step(mk("t3_wait", SWait, NON, 0, 1, 2, 0, 0));
    step(mk("t3_commit", SCom, COM, 1, 1, 2, 0, 0));
    tx_en = 1'b1;
    step(mk("t3_tx", STx, NON, 0, 1, 2, 0, 0));
    tx_en = 1'b0; packet_pending = 1'b0;
    step(mk("t3_next", SNxt, NON, 0, 1, 3, 0, 1));
    step(mk("t3_pulse_end", SWait, NON, 0, 1, 3, 0, 0));

    // Burst up to max_bc=2.
    max_bc = 8'd2;
    sync_to_commit1();
    tx_en = 1'b1;
    step(mk("t4_tx1", STx, NON, 1, 1, 1, 0, 0));
    tx_en = 1'b0;
    step(mk("t4_burst1", SBur, COM, 1, 1, 1, 1, 0));
    tx_en = 1'b1;
    step(mk("t4_tx2", STx, NON, 1, 1, 1, 1, 0));
    tx_en = 1'b0;
    step(mk("t4_burst2", SBur, COM, 1, 1, 1, 2, 0));
    tx_en = 1'b1;
    step(mk("t4_tx3", STx, NON, 0, 1, 1, 2, 0));
    tx_en = 1'b0; packet_pending = 1'b0;
    step(mk("t4_next", SNxt, NON, 0, 1, 2, 2, 1));

    // Burst timer expiry with no follow-on packet.
    sync_to_commit1();
    tx_en = 1'b1; packet_pending = 1'b0;
    step(mk("bt_tx", STx, NON, 1, 1, 1, 0, 0));
    tx_en = 1'b0;
    step(mk("bt_burst", SBur, COM, 1, 1, 1, 1, 0));
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state == SBur && n < 1000);
    cmp("bt_len", "edges", 32'(n), 32'(BURST_CYC));
    check_out(mk("bt_abort", SAbt, NON, 0, 1, 1, 1, 0));
    step(mk("bt_next", SNxt, NON, 0, 1, 2, 1, 1));

    // Disable while transmitting.
    sync_to_commit1();
    tx_en = 1'b1; packet_pending = 1'b0;
    step(mk("t6_tx", STx, NON, 1, 1, 1, 0, 0));
    plca_en = 1'b0;
    step(mk("t6_dis", SDis, NON, 0, 0, 0, 0, 0));
    tx_en = 1'b0;

    // Coordinator cycle with node_count=4.
    plca_en = 1'b1; local_node_id = 8'd0; max_bc = 8'd0;
    step(mk("t2_recover", SRec, NON, 0, 0, 0, 0, 0));
    step(mk("t2_wait", SWait, NON, 0, 0, 0, 0, 0));
    wait_txop("t2_txop1", TO_CYC, 1);
    wait_txop("t2_txop2", TO_CYC + 1, 2);
    wait_txop("t2_txop3", TO_CYC + 1, 3);
    wait_txop("t2_txop4", TO_CYC + 1, 4);
    step(mk("t2_resync", SRes, NON, 0, 0, 4, 0, 0));
    step(mk("t2_beacon", SSnd, BCN, 0, 1, 4, 0, 0));
    n = 1;
    do begin
      @(posedge clk);
      #1;
      if (state == SSnd && tx_cmd == BCN) n++;
    end while (state == SSnd && n < 100);
    cmp("t2_beacon_len", "cycles", 32'(n), 32'(BEACON_CYC));
    check_out(mk("t2_syncing", SSyn, NON, 0, 1, 0, 0, 0));
    step(mk("t2_wait2", SWait, NON, 0, 1, 0, 0, 0));

    // Invalid beacon timeout for follower id=5.
    sync_follower(8'd5);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state != SRes && n < 5000);
    cmp("t5_len", "edges", 32'(n), 32'(INV_BEACON_CYC));
    cmp("t5_resync", "state", 32'(state), 32'(SRes));
    cmp("t5_resync", "plca_active", 32'(plca_active), 32'd0);
    cmp("t5_resync", "cur_id", 32'(cur_id), 32'(1 + (INV_BEACON_CYC - TO_CYC) / (TO_CYC + 1)));
    @(posedge clk);
    #1;
    cmp("t5_hold", "state", 32'(state), 32'(SRes));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
